// File: rtl/dec_onehot2bin.sv
// One-hot to binary decoder with valid/ready handshake, a 2-entry skid
// buffer (registered output, full throughput), illegal-word detection and
// a saturating count of accepted illegal words.
module dec_onehot2bin #(
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2**OUT_W-2:0]    in,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out,
  output logic                   out_err,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int N = 2**OUT_W - 1;
  localparam logic [N-1:0]     ONE     = N'(1);
  localparam logic [OUT_W-1:0] ILL     = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-bit contribution: bit k set contributes index k, else zero.
  logic [N-1:0][OUT_W-1:0] idx_mask;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_bit
      assign idx_mask[k] = in[k] ? OUT_W'(k) : '0;
    end
  endgenerate

  logic [OUT_W-1:0] idx_or;
  logic             legal;
  logic [OUT_W-1:0] dec_code;
  logic             dec_err;

  // OR the per-bit indices; exactly-one-hot check via x & (x-1) == 0.
  always_comb begin
    idx_or = '0;
    for (int i = 0; i < N; i++) idx_or = idx_or | idx_mask[i];
    legal    = (in != '0) && ((in & (in - ONE)) == '0);
    dec_code = legal ? idx_or : ILL;
    dec_err  = !legal;
  end

  logic             skid_valid;
  logic [OUT_W-1:0] skid_code;
  logic             skid_err;
  logic             in_xfer;
  logic             out_free;

  // Skid register gates acceptance, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid && !rst;
  assign in_xfer  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Output register plus skid entry; skid refills output when it frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_code  <= '0;
      skid_err   <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out        <= skid_code;
        out_err    <= skid_err;
        out_valid  <= 1'b1;
        skid_valid <= in_xfer;
        if (in_xfer) begin
          skid_code <= dec_code;
          skid_err  <= dec_err;
        end
      end else if (in_xfer) begin
        out       <= dec_code;
        out_err   <= dec_err;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_code  <= dec_code;
      skid_err   <= dec_err;
      skid_valid <= 1'b1;
    end
  end

  // Count accepted illegal words, holding at the maximum.
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (in_xfer && dec_err && err_cnt != CNT_MAX)
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule
